// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter on a 4-register AVR I/O window.
// Drives PS2Clk/PS2Data open-drain via output enables (1 = pull low).
// Optional feature macro: PS2TX_IRQ_EN (IE bit and transfer-complete irq).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1250,
    parameter int TIMEOUT_CYCLES = 187500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [1:0] io_a,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       irq
);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_XFER, S_ACK, S_RELEASE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [7:0]  r_data;
    logic        r_par, r_dbit;
    logic [3:0]  r_cnt;
    logic [17:0] r_tmr;
    logic        r_done, r_nack, r_tout;

    logic w_fall, w_accept, w_rd_stat, w_wr_stat, w_busy, w_inh_last, w_tmo;
    logic w_dbit_nxt, w_set_nack, w_set_done, w_set_tout, w_ie;

    assign w_fall     = r_clk_prev & ~r_clk_s2;
    assign w_busy     = (r_state != S_IDLE);
    assign w_accept   = io_we && (io_a == 2'd0) && !w_busy;
    assign w_rd_stat  = io_re && (io_a == 2'd1);
    assign w_wr_stat  = io_we && (io_a == 2'd1);
    assign w_inh_last = (r_state == S_INHIBIT) && (r_tmr == 18'(INHIBIT_CYCLES - 1));
    assign w_tmo      = (r_tmr == 18'(TIMEOUT_CYCLES - 1));

    // Two-stage synchronizers plus previous clock level for falling-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Next-state and per-edge bit selection
    always_comb begin
        w_state_nxt = r_state;
        w_dbit_nxt  = r_dbit;
        w_set_nack  = 1'b0;
        w_set_done  = 1'b0;
        w_set_tout  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_INHIBIT;
            S_INHIBIT: begin
                w_dbit_nxt = 1'b1;                 // start bit held into XFER
                if (w_inh_last) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_set_tout  = 1'b1;
                    w_set_done  = 1'b1;
                end else if (w_fall) begin
                    case (r_cnt)
                        4'd0, 4'd1, 4'd2, 4'd3,
                        4'd4, 4'd5, 4'd6, 4'd7: w_dbit_nxt = ~r_data[r_cnt[2:0]];
                        4'd8:                   w_dbit_nxt = ~r_par;
                        4'd9:                   w_dbit_nxt = 1'b0;   // stop: release line
                        default:                w_state_nxt = S_ACK; // edge 11
                    endcase
                end
            end
            S_ACK: begin
                w_set_nack  = r_dat_s2;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                    w_set_tout  = 1'b1;
                    w_set_done  = 1'b1;
                end else if (r_clk_s2 && r_dat_s2) begin
                    w_state_nxt = S_IDLE;
                    w_set_done  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, edge counter, event timer and shift data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_tmr   <= 18'd0;
            r_dbit  <= 1'b0;
            r_data  <= 8'h00;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dbit  <= w_dbit_nxt;
            if (w_accept) begin
                r_data <= io_din;
                r_par  <= ~^io_din;
            end
            if (r_state != S_XFER)
                r_cnt <= 4'd0;
            else if (w_fall)
                r_cnt <= r_cnt + 4'd1;
            // The clock we pull low during INHIBIT looks like a fall; don't let it restart the count
            if (r_state == S_IDLE || w_state_nxt != r_state || (w_fall && r_state != S_INHIBIT))
                r_tmr <= 18'd0;
            else
                r_tmr <= r_tmr + 18'd1;
        end
    end

    // Status flags: read/accept clears first so a same-cycle set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            r_tout <= 1'b0;
        end else begin
            if (w_rd_stat || w_accept) begin
                r_done <= 1'b0;
                r_nack <= 1'b0;
                r_tout <= 1'b0;
            end
            if (w_set_done) r_done <= 1'b1;
            if (w_set_nack) r_nack <= 1'b1;
            if (w_set_tout) r_tout <= 1'b1;
        end
    end

`ifdef PS2TX_IRQ_EN
    logic r_ie, r_irq;

    // Interrupt enable and registered completion interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_stat) r_ie <= io_din[7];
            r_irq <= r_ie & r_done;
        end
    end
    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    logic w_unused;
    assign w_unused = w_wr_stat;
    assign w_ie     = 1'b0;
    assign irq      = 1'b0;
`endif

    assign ps2_clk_oe  = (r_state == S_INHIBIT);
    assign ps2_data_oe = w_inh_last | ((r_state == S_XFER) & r_dbit);

    // Read mux, zero when not reading
    always_comb begin
        io_dout = 8'h00;
        if (io_re) begin
            case (io_a)
                2'd0:    io_dout = r_data;
                2'd1:    io_dout = {w_ie, 3'b000, r_tout, r_nack, r_done, w_busy};
                default: io_dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model on open-drain pins.
module tb_ps2_host_tx;
    localparam int INH  = 1250;
    localparam int TMO  = 3000;
    localparam int HALF = 50;

    logic       clk = 1'b0, rst = 1'b1;
    logic       io_re = 1'b0, io_we = 1'b0;
    logic [1:0] io_a = 2'd0;
    logic [7:0] io_din = 8'h00;
    logic [7:0] io_dout;
    logic       ps2_clk_oe, ps2_data_oe, irq;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    wire        clk_pin  = ~ps2_clk_oe & dev_clk;
    wire        data_pin = ~ps2_data_oe & dev_data;
    int         n_pass = 0, n_chk = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_din(io_din), .io_dout(io_dout), .ps2_clk_in(clk_pin),
        .ps2_data_in(data_pin), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        io_we = 1'b1; io_a = a; io_din = d;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        io_re = 1'b1; io_a = a;
        #1 d = io_dout;
        @(negedge clk);
        io_re = 1'b0;
    endtask

    // Count cycles the host holds the clock low, starting right after the write
    task automatic wait_inhibit(output int len);
        len = 0;
        while (ps2_clk_oe === 1'b1 && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Device clocks n_edges pulses; captures data on each rising edge
    task automatic device_frame(input int n_edges, input logic nack, output logic [10:0] bits);
        bits = '0;
        bits[0] = data_pin;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11) dev_data = nack;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (e <= 10) bits[e] = data_pin;
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        n_chk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        rd(2'd0, d);
        n_chk++; if (d !== 8'h00) $display("FAIL reset_data: got %h want 00", d); else n_pass++;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h00) $display("FAIL reset_status: got %h want 00", d); else n_pass++;
        rd(2'd2, d);
        n_chk++; if (d !== 8'h00) $display("FAIL reg2: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_ack;
        int len; logic [10:0] bits; logic [7:0] d;
        wr(2'd0, 8'hED);
        wait_inhibit(len);
        n_chk++; if (len != INH) $display("FAIL inhibit_len: got %0d want %0d", len, INH); else n_pass++;
        device_frame(11, 1'b0, bits);
        n_chk++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) $display("FAIL ack_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hED, 1'b0}); else n_pass++;
        repeat (10) @(negedge clk);
        rd(2'd1, d);
        n_chk++; if (d !== 8'h02) $display("FAIL ack_status: got %h want 02", d); else n_pass++;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h00) $display("FAIL ack_status2: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_nack;
        int len; logic [10:0] bits; logic [7:0] d;
        wr(2'd0, 8'hFF);
        wait_inhibit(len);
        device_frame(11, 1'b1, bits);
        n_chk++; if (bits !== {1'b1, 1'b1, 8'hFF, 1'b0}) $display("FAIL nack_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hFF, 1'b0}); else n_pass++;
        repeat (10) @(negedge clk);
        rd(2'd1, d);
        n_chk++; if (d !== 8'h06) $display("FAIL nack_status: got %h want 06", d); else n_pass++;
    endtask

    task automatic test_timeout;
        int len; logic [7:0] d;
        wr(2'd0, 8'hF3);
        wait_inhibit(len);
        n_chk++; if (len != INH) $display("FAIL tmo_inhibit_len: got %0d want %0d", len, INH); else n_pass++;
        repeat (TMO - 20) @(negedge clk);
        n_chk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) $display("FAIL tmo_early: got %b want 01", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
        repeat (40) @(negedge clk);
        n_chk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL tmo_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h0A) $display("FAIL tmo_status: got %h want 0A", d); else n_pass++;
    endtask

    task automatic test_busy_write;
        int len; logic [10:0] bits; logic [7:0] d;
        wr(2'd0, 8'hED);
        rd(2'd1, d);
        n_chk++; if (d !== 8'h01) $display("FAIL busy_status: got %h want 01", d); else n_pass++;
        wait_inhibit(len);
        wr(2'd0, 8'h55);
        rd(2'd0, d);
        n_chk++; if (d !== 8'hED) $display("FAIL busy_data: got %h want ED", d); else n_pass++;
        device_frame(11, 1'b0, bits);
        n_chk++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) $display("FAIL busy_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hED, 1'b0}); else n_pass++;
        repeat (10) @(negedge clk);
        rd(2'd1, d);
        n_chk++; if (d !== 8'h02) $display("FAIL busy_done: got %h want 02", d); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int len; logic [10:0] bits; logic [7:0] d;
        wr(2'd0, 8'hED);
        wait_inhibit(len);
        device_frame(5, 1'b0, bits);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL mid_rst_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
        rst = 1'b0;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h00) $display("FAIL mid_rst_status: got %h want 00", d); else n_pass++;
        wr(2'd0, 8'hF4);
        wait_inhibit(len);
        device_frame(11, 1'b0, bits);
        n_chk++; if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) $display("FAIL f4_bits: got %b want %b", bits, {1'b1, 1'b0, 8'hF4, 1'b0}); else n_pass++;
        repeat (10) @(negedge clk);
        rd(2'd1, d);
        n_chk++; if (d !== 8'h02) $display("FAIL f4_status: got %h want 02", d); else n_pass++;
    endtask

    task automatic test_irq;
        int len; logic [10:0] bits; logic [7:0] d; logic seen;
        wr(2'd1, 8'h80);
        rd(2'd1, d);
`ifdef PS2TX_IRQ_EN
        n_chk++; if (d !== 8'h80) $display("FAIL ie_readback: got %h want 80", d); else n_pass++;
`else
        n_chk++; if (d !== 8'h00) $display("FAIL ie_readback: got %h want 00", d); else n_pass++;
`endif
        wr(2'd0, 8'hED);
        wait_inhibit(len);
        device_frame(11, 1'b0, bits);
`ifdef PS2TX_IRQ_EN
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = irq;
        end
        n_chk++; if (seen !== 1'b1) $display("FAIL irq_rise: got %b want 1", seen); else n_pass++;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h82) $display("FAIL irq_status: got %h want 82", d); else n_pass++;
        @(negedge clk);
        n_chk++; if (irq !== 1'b0) $display("FAIL irq_drop: got %b want 0", irq); else n_pass++;
`else
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            seen = seen | irq;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL irq_tied: got %b want 0", seen); else n_pass++;
        rd(2'd1, d);
        n_chk++; if (d !== 8'h02) $display("FAIL poll_status: got %h want 02", d); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_ack();
        test_nack();
        test_timeout();
        test_busy_write();
        test_reset_mid();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
